// File: rtl/cop0_exc_ctrl.sv
// Exception collector/prioritiser ahead of COP0; optional bus-error sources under COP0_EXC_BUS_ERR_EN.
// Latency: request sampled in IDLE at cycle N, registered exception outputs valid at N+1 (state EXC).
// Backpressure: STALL_IN holds off sampling in IDLE only; EXC and DRAIN block all requests.
module cop0_exc_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST_ASYNC_N,
    input  logic        STALL_IN,
    input  logic        IF_ADEL_IN,
    input  logic [31:0] IF_PC_IN,
    input  logic        IF_BD_IN,
    input  logic        ID_CPU_IN,
    input  logic [1:0]  ID_CPU_CE_IN,
    input  logic        ID_RI_IN,
    input  logic        ID_SYS_IN,
    input  logic        ID_BP_IN,
    input  logic [31:0] ID_PC_IN,
    input  logic        ID_BD_IN,
    input  logic        EX_OVF_IN,
    input  logic [31:0] EX_PC_IN,
    input  logic        EX_BD_IN,
    input  logic        MEM_VALID_IN,
    input  logic        MEM_ADEL_IN,
    input  logic        MEM_ADES_IN,
    input  logic [31:0] MEM_ADDR_IN,
    input  logic [31:0] MEM_PC_IN,
    input  logic        MEM_BD_IN,
`ifdef COP0_EXC_BUS_ERR_EN
    input  logic        IF_IBE_IN,
    input  logic        MEM_DBE_IN,
`endif
    input  logic        COP0_INT_IN,
    input  logic [31:0] COP0_VECTOR_IN,
    output logic        CORE_EXC_EN_OUT,
    output logic [1:0]  CORE_EXC_CE_OUT,
    output logic [4:0]  CORE_EXC_CODE_OUT,
    output logic        CORE_EXC_BD_OUT,
    output logic [31:0] CORE_EXC_EPC_OUT,
    output logic [31:0] CORE_EXC_BADVA_OUT,
    output logic [3:0]  PIPE_FLUSH_OUT,
    output logic        PC_REDIRECT_EN_OUT,
    output logic [31:0] PC_REDIRECT_ADDR_OUT,
    output logic        EXC_BUSY_OUT
);

    localparam logic [4:0] CODE_INT  = 5'd0;
    localparam logic [4:0] CODE_ADEL = 5'd4;
    localparam logic [4:0] CODE_ADES = 5'd5;
    localparam logic [4:0] CODE_SYS  = 5'd8;
    localparam logic [4:0] CODE_BP   = 5'd9;
    localparam logic [4:0] CODE_RI   = 5'd10;
    localparam logic [4:0] CODE_CPU  = 5'd11;
    localparam logic [4:0] CODE_OV   = 5'd12;
`ifdef COP0_EXC_BUS_ERR_EN
    localparam logic [4:0] CODE_IBE  = 5'd6;
    localparam logic [4:0] CODE_DBE  = 5'd7;
`endif
    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXC   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  drain_cnt;

    logic        req_vld;
    logic [4:0]  req_code;
    logic [1:0]  req_ce;
    logic        req_bd;
    logic [31:0] req_epc;
    logic        badva_ld;
    logic [31:0] badva_nxt;
    logic        int_req;

    logic        exc_en;
    logic [1:0]  exc_ce;
    logic [4:0]  exc_code;
    logic        exc_bd;
    logic [31:0] exc_epc;
    logic [31:0] exc_badva;
    logic [3:0]  flush;
    logic        redir_en;
    logic [31:0] redir_addr;
    logic        busy;

    // An interrupt is attributed to the MEM instruction, so it needs a real one there.
    assign int_req = COP0_INT_IN & MEM_VALID_IN;

    // Oldest stage wins; within ID the architectural order CpU > RI > Sys > Bp.
    always_comb begin
        req_vld   = 1'b1;
        req_code  = CODE_INT;
        req_ce    = 2'b00;
        req_bd    = 1'b0;
        req_epc   = 32'h0;
        badva_ld  = 1'b0;
        badva_nxt = MEM_ADDR_IN;
        if (MEM_ADEL_IN) begin
            req_code = CODE_ADEL;
            req_bd   = MEM_BD_IN;
            req_epc  = MEM_PC_IN;
            badva_ld = 1'b1;
        end else if (MEM_ADES_IN) begin
            req_code = CODE_ADES;
            req_bd   = MEM_BD_IN;
            req_epc  = MEM_PC_IN;
            badva_ld = 1'b1;
`ifdef COP0_EXC_BUS_ERR_EN
        end else if (MEM_DBE_IN) begin
            req_code = CODE_DBE;
            req_bd   = MEM_BD_IN;
            req_epc  = MEM_PC_IN;
`endif
        end else if (int_req) begin
            req_code = CODE_INT;
            req_bd   = MEM_BD_IN;
            req_epc  = MEM_PC_IN;
        end else if (EX_OVF_IN) begin
            req_code = CODE_OV;
            req_bd   = EX_BD_IN;
            req_epc  = EX_PC_IN;
        end else if (ID_CPU_IN) begin
            req_code = CODE_CPU;
            req_ce   = ID_CPU_CE_IN;
            req_bd   = ID_BD_IN;
            req_epc  = ID_PC_IN;
        end else if (ID_RI_IN) begin
            req_code = CODE_RI;
            req_bd   = ID_BD_IN;
            req_epc  = ID_PC_IN;
        end else if (ID_SYS_IN) begin
            req_code = CODE_SYS;
            req_bd   = ID_BD_IN;
            req_epc  = ID_PC_IN;
        end else if (ID_BP_IN) begin
            req_code = CODE_BP;
            req_bd   = ID_BD_IN;
            req_epc  = ID_PC_IN;
        end else if (IF_ADEL_IN) begin
            req_code  = CODE_ADEL;
            req_bd    = IF_BD_IN;
            req_epc   = IF_PC_IN;
            badva_ld  = 1'b1;
            badva_nxt = IF_PC_IN;
`ifdef COP0_EXC_BUS_ERR_EN
        end else if (IF_IBE_IN) begin
            req_code = CODE_IBE;
            req_bd   = IF_BD_IN;
            req_epc  = IF_PC_IN;
`endif
        end else begin
            req_vld = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
        if (!RST_ASYNC_N) begin
            state      <= ST_IDLE;
            drain_cnt  <= 4'd0;
            exc_en     <= 1'b0;
            exc_ce     <= 2'b00;
            exc_code   <= 5'd0;
            exc_bd     <= 1'b0;
            exc_epc    <= 32'h0;
            exc_badva  <= 32'h0;
            flush      <= 4'h0;
            redir_en   <= 1'b0;
            redir_addr <= 32'h0;
            busy       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!STALL_IN && req_vld) begin
                        state      <= ST_EXC;
                        exc_en     <= 1'b1;
                        exc_ce     <= req_ce;
                        exc_code   <= req_code;
                        exc_bd     <= req_bd;
                        exc_epc    <= req_epc;
                        flush      <= 4'hF;
                        redir_en   <= 1'b1;
                        redir_addr <= COP0_VECTOR_IN;
                        busy       <= 1'b1;
                        // COP0 captures BadVA on every pulse; holding it keeps the register intact.
                        if (badva_ld) begin
                            exc_badva <= badva_nxt;
                        end
                    end
                end
                ST_EXC: begin
                    state     <= ST_DRAIN;
                    exc_en    <= 1'b0;
                    redir_en  <= 1'b0;
                    drain_cnt <= DRAIN_INIT;
                end
                ST_DRAIN: begin
                    if (drain_cnt <= 4'd1) begin
                        state     <= ST_IDLE;
                        drain_cnt <= 4'd0;
                        flush     <= 4'h0;
                        busy      <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt - 4'd1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    drain_cnt <= 4'd0;
                    exc_en    <= 1'b0;
                    flush     <= 4'h0;
                    redir_en  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign CORE_EXC_EN_OUT      = exc_en;
    assign CORE_EXC_CE_OUT      = exc_ce;
    assign CORE_EXC_CODE_OUT    = exc_code;
    assign CORE_EXC_BD_OUT      = exc_bd;
    assign CORE_EXC_EPC_OUT     = exc_epc;
    assign CORE_EXC_BADVA_OUT   = exc_badva;
    assign PIPE_FLUSH_OUT       = flush;
    assign PC_REDIRECT_EN_OUT   = redir_en;
    assign PC_REDIRECT_ADDR_OUT = redir_addr;
    assign EXC_BUSY_OUT         = busy;

endmodule

// File: tb/tb_cop0_exc_ctrl.sv
// Directed bench for cop0_exc_ctrl with DRAIN_CYCLES=2.
module tb_cop0_exc_ctrl;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        if_adel;
    logic [31:0] if_pc;
    logic        if_bd;
    logic        id_cpu;
    logic [1:0]  id_cpu_ce;
    logic        id_ri;
    logic        id_sys;
    logic        id_bp;
    logic [31:0] id_pc;
    logic        id_bd;
    logic        ex_ovf;
    logic [31:0] ex_pc;
    logic        ex_bd;
    logic        mem_valid;
    logic        mem_adel;
    logic        mem_ades;
    logic [31:0] mem_addr;
    logic [31:0] mem_pc;
    logic        mem_bd;
`ifdef COP0_EXC_BUS_ERR_EN
    logic        if_ibe;
    logic        mem_dbe;
`endif
    logic        cop0_int;
    logic [31:0] cop0_vector;
    logic        exc_en;
    logic [1:0]  exc_ce;
    logic [4:0]  exc_code;
    logic        exc_bd;
    logic [31:0] exc_epc;
    logic [31:0] exc_badva;
    logic [3:0]  flush;
    logic        redir_en;
    logic [31:0] redir_addr;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int pulses;

    cop0_exc_ctrl #(.DRAIN_CYCLES(2)) dut (
        .CLK(clk), .RST_ASYNC_N(rst_n), .STALL_IN(stall),
        .IF_ADEL_IN(if_adel), .IF_PC_IN(if_pc), .IF_BD_IN(if_bd),
        .ID_CPU_IN(id_cpu), .ID_CPU_CE_IN(id_cpu_ce), .ID_RI_IN(id_ri),
        .ID_SYS_IN(id_sys), .ID_BP_IN(id_bp), .ID_PC_IN(id_pc), .ID_BD_IN(id_bd),
        .EX_OVF_IN(ex_ovf), .EX_PC_IN(ex_pc), .EX_BD_IN(ex_bd),
        .MEM_VALID_IN(mem_valid), .MEM_ADEL_IN(mem_adel), .MEM_ADES_IN(mem_ades),
        .MEM_ADDR_IN(mem_addr), .MEM_PC_IN(mem_pc), .MEM_BD_IN(mem_bd),
`ifdef COP0_EXC_BUS_ERR_EN
        .IF_IBE_IN(if_ibe), .MEM_DBE_IN(mem_dbe),
`endif
        .COP0_INT_IN(cop0_int), .COP0_VECTOR_IN(cop0_vector),
        .CORE_EXC_EN_OUT(exc_en), .CORE_EXC_CE_OUT(exc_ce),
        .CORE_EXC_CODE_OUT(exc_code), .CORE_EXC_BD_OUT(exc_bd),
        .CORE_EXC_EPC_OUT(exc_epc), .CORE_EXC_BADVA_OUT(exc_badva),
        .PIPE_FLUSH_OUT(flush), .PC_REDIRECT_EN_OUT(redir_en),
        .PC_REDIRECT_ADDR_OUT(redir_addr), .EXC_BUSY_OUT(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        stall = 1'b0; if_adel = 1'b0; if_pc = 32'h0; if_bd = 1'b0;
        id_cpu = 1'b0; id_cpu_ce = 2'd0; id_ri = 1'b0; id_sys = 1'b0; id_bp = 1'b0;
        id_pc = 32'h0; id_bd = 1'b0; ex_ovf = 1'b0; ex_pc = 32'h0; ex_bd = 1'b0;
        mem_valid = 1'b0; mem_adel = 1'b0; mem_ades = 1'b0; mem_addr = 32'h0;
        mem_pc = 32'h0; mem_bd = 1'b0; cop0_int = 1'b0;
`ifdef COP0_EXC_BUS_ERR_EN
        if_ibe = 1'b0; mem_dbe = 1'b0;
`endif
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'h0, busy}, 32'h0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_en"},    {31'h0, exc_en}, 32'h0);
        chk({tag, "_code"},  {27'h0, exc_code}, 32'h0);
        chk({tag, "_ce"},    {30'h0, exc_ce}, 32'h0);
        chk({tag, "_bd"},    {31'h0, exc_bd}, 32'h0);
        chk({tag, "_epc"},   exc_epc, 32'h0);
        chk({tag, "_badva"}, exc_badva, 32'h0);
        chk({tag, "_flush"}, {28'h0, flush}, 32'h0);
        chk({tag, "_rden"},  {31'h0, redir_en}, 32'h0);
        chk({tag, "_rdadr"}, redir_addr, 32'h0);
        chk({tag, "_busy"},  {31'h0, busy}, 32'h0);
    endtask

    // Expects the pulse at the current negedge; then clears and waits for IDLE.
    task automatic chk_pulse(input string tag, input logic [4:0] code, input logic [31:0] badva);
        chk({tag, "_en"},    {31'h0, exc_en}, 32'h1);
        chk({tag, "_code"},  {27'h0, exc_code}, {27'h0, code});
        chk({tag, "_badva"}, exc_badva, badva);
        clear_inputs();
        wait_idle({tag, "_idle"});
    endtask

    initial begin
        clear_inputs();
        cop0_vector = 32'h8000_0080;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Overflow: pulse, flush, redirect, then two drain cycles.
        ex_ovf = 1'b1; ex_pc = 32'h8000_0104;
        @(negedge clk);
        chk("ov_en", {31'h0, exc_en}, 32'h1);
        chk("ov_code", {27'h0, exc_code}, 32'd12);
        chk("ov_epc", exc_epc, 32'h8000_0104);
        chk("ov_bd", {31'h0, exc_bd}, 32'h0);
        chk("ov_ce", {30'h0, exc_ce}, 32'h0);
        chk("ov_flush", {28'h0, flush}, 32'hF);
        chk("ov_rden", {31'h0, redir_en}, 32'h1);
        chk("ov_rdadr", redir_addr, 32'h8000_0080);
        chk("ov_busy", {31'h0, busy}, 32'h1);
        chk("ov_badva", exc_badva, 32'h0);
        clear_inputs();
        @(negedge clk);
        chk("ov_d1_en", {31'h0, exc_en}, 32'h0);
        chk("ov_d1_rden", {31'h0, redir_en}, 32'h0);
        chk("ov_d1_flush", {28'h0, flush}, 32'hF);
        @(negedge clk);
        chk("ov_d2_flush", {28'h0, flush}, 32'hF);
        chk("ov_d2_busy", {31'h0, busy}, 32'h1);
        @(negedge clk);
        chk("ov_end_flush", {28'h0, flush}, 32'h0);
        chk("ov_end_busy", {31'h0, busy}, 32'h0);

        // AdES beats simultaneous Sys; Sys must not follow.
        mem_ades = 1'b1; mem_addr = 32'h0000_1003; id_sys = 1'b1; id_pc = 32'h8000_0300;
        @(negedge clk);
        chk("ades_en", {31'h0, exc_en}, 32'h1);
        chk("ades_code", {27'h0, exc_code}, 32'd5);
        chk("ades_badva", exc_badva, 32'h0000_1003);
        clear_inputs();
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (exc_en) pulses++;
        end
        chk("ades_no_sys", pulses, 0);

        // CpU in delay slot; BadVA must hold.
        id_cpu = 1'b1; id_cpu_ce = 2'd2; id_bd = 1'b1; id_pc = 32'hBFC0_0010;
        @(negedge clk);
        chk("cpu_ce", {30'h0, exc_ce}, 32'h2);
        chk("cpu_bd", {31'h0, exc_bd}, 32'h1);
        chk("cpu_epc", exc_epc, 32'hBFC0_0010);
        chk_pulse("cpu", 5'd11, 32'h0000_1003);

        // Priority corners.
        mem_adel = 1'b1; mem_ades = 1'b1; mem_addr = 32'h0000_2001;
        @(negedge clk);
        chk_pulse("adel_ades", 5'd4, 32'h0000_2001);
        id_ri = 1'b1; id_sys = 1'b1; id_bp = 1'b1; if_adel = 1'b1; if_pc = 32'h0000_0031;
        @(negedge clk);
        chk_pulse("ri_first", 5'd10, 32'h0000_2001);
        id_sys = 1'b1; id_bp = 1'b1;
        @(negedge clk);
        chk_pulse("sys_bp", 5'd8, 32'h0000_2001);
        id_bp = 1'b1; if_adel = 1'b1; if_pc = 32'h0000_0041;
        @(negedge clk);
        chk_pulse("bp_ifadel", 5'd9, 32'h0000_2001);
        cop0_int = 1'b1; mem_valid = 1'b0; ex_ovf = 1'b1;
        @(negedge clk);
        chk_pulse("int_novalid", 5'd12, 32'h0000_2001);
        cop0_int = 1'b1; mem_valid = 1'b1; ex_ovf = 1'b1; id_cpu = 1'b1; id_cpu_ce = 2'd3;
        @(negedge clk);
        chk("int_ov_ce", {30'h0, exc_ce}, 32'h0);
        chk_pulse("int_ov", 5'd0, 32'h0000_2001);

        // Interrupt held 4 cycles: exactly one pulse.
        cop0_int = 1'b1; mem_valid = 1'b1; mem_pc = 32'h8000_0200;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (exc_en) begin
                pulses++;
                chk("int_code", {27'h0, exc_code}, 32'd0);
                chk("int_epc", exc_epc, 32'h8000_0200);
            end
            if (i == 3) clear_inputs();
        end
        chk("int_pulses", pulses, 1);

        // Stalled IF AdEL is taken one cycle after release.
        stall = 1'b1; if_adel = 1'b1; if_pc = 32'h0000_0002;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (exc_en) pulses++;
        end
        chk("stall_none", pulses, 0);
        stall = 1'b0;
        @(negedge clk);
        chk("ifadel_en", {31'h0, exc_en}, 32'h1);
        chk("ifadel_code", {27'h0, exc_code}, 32'd4);
        chk("ifadel_badva", exc_badva, 32'h0000_0002);
        chk("ifadel_epc", exc_epc, 32'h0000_0002);
        clear_inputs();

        // Async reset in DRAIN.
        @(negedge clk);
        chk("drain_busy", {31'h0, busy}, 32'h1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("rst_drain");
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (exc_en) pulses++;
        end
        chk("post_rst_pulses", pulses, 0);
        chk("post_rst_busy", {31'h0, busy}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
